// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO interconnect.
// Holds the FSM encoding plus the stock window map used when a top is left unparameterised.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [31:0]  ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic [127:0] DEV_BASE_DEF = {32'hFFFF_0030, 32'hFFFF_0020,
                                           32'hFFFF_0010, 32'hFFFF_0000};
  localparam logic [127:0] DEV_MASK_DEF = {4{32'hFFFF_FFF0}};

  // Slot index width, kept at least one bit so a single-device build still has a port.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_window_decode.sv
// Combinational address decoder: matches an address against N base/mask windows.
// The lowest matching index wins; the offset is taken with the winning window's mask.
module mmio_window_decode
  import mmio_pkg::*;
#(
  parameter int                        N_DEV    = 4,
  parameter int                        ADDR_W   = 32,
  parameter logic [N_DEV*ADDR_W-1:0]   DEV_BASE = DEV_BASE_DEF,
  parameter logic [N_DEV*ADDR_W-1:0]   DEV_MASK = DEV_MASK_DEF,
  localparam int                       SLOT_W   = slot_width(N_DEV)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_DEV-1:0]  hit_vec_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              hit_o,
  output logic [ADDR_W-1:0] offset_o
);

  logic [N_DEV-1:0] match;

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_match
    assign match[gi] = ((addr_i & DEV_MASK[gi*ADDR_W +: ADDR_W]) ==
                        (DEV_BASE[gi*ADDR_W +: ADDR_W] & DEV_MASK[gi*ADDR_W +: ADDR_W]));
  end

  logic [ADDR_W-1:0] mask_sel;

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    hit_vec_o = '0;
    slot_o    = '0;
    hit_o     = 1'b0;
    mask_sel  = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_vec_o    = '0;
        hit_vec_o[i] = 1'b1;
        slot_o       = SLOT_W'(i);
        hit_o        = 1'b1;
        mask_sel     = DEV_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign offset_o = addr_i & ~mask_sel;

endmodule

// File: rtl/mmio_bus.sv
// MMIO interconnect: routes one held read/write request to one of N devices over sel/ack,
// returning a one-cycle done pulse with data, or an error on unmapped/illegal/timeout.
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int                      N_DEV    = 4,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter int                      TIMEOUT  = 255,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = DEV_BASE_DEF,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = DEV_MASK_DEF,
  parameter logic [DATA_W-1:0]       ERR_DATA = ERR_DATA_DEF
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    mmio_read,
  input  logic                    mmio_write,
  input  logic [ADDR_W-1:0]       mmio_addr,
  input  logic [DATA_W-1:0]       mmio_write_data,
  output logic                    mmio_read_done,
  output logic                    mmio_write_done,
  output logic [DATA_W-1:0]       mmio_read_data,
  output logic                    mmio_err,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_we,
  output logic [ADDR_W-1:0]       dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ack
);

  localparam int              SLOT_W   = slot_width(N_DEV);
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [N_DEV-1:0]    sel_q, sel_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N_DEV-1:0]    dec_hit_vec;
  logic [SLOT_W-1:0]   dec_slot;
  logic                dec_hit;
  logic [ADDR_W-1:0]   dec_offset;

  mmio_window_decode #(
    .N_DEV    (N_DEV),
    .ADDR_W   (ADDR_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .addr_i    (mmio_addr),
    .hit_vec_o (dec_hit_vec),
    .slot_o    (dec_slot),
    .hit_o     (dec_hit),
    .offset_o  (dec_offset)
  );

  logic [DATA_W-1:0] rdata_arr [N_DEV];

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_rdata
    assign rdata_arr[gi] = dev_rdata[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    sel_d   = sel_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mmio_read || mmio_write) begin
          rd_d = mmio_read;
          wr_d = mmio_write;
          if ((mmio_read && mmio_write) || !dec_hit) begin
            err_d = 1'b1;
            if (mmio_read) rdata_d = ERR_DATA;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            sel_d   = dec_hit_vec;
            slot_d  = dec_slot;
            addr_d  = dec_offset;
            wdata_d = mmio_write_data;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (dev_ack[slot_q]) begin
          err_d = 1'b0;
          if (rd_q) rdata_d = rdata_arr[slot_q];
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (rd_q) rdata_d = ERR_DATA;
          state_d = RESP;
        end
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = HOLD;
      HOLD: begin
        if (!mmio_read && !mmio_write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      slot_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dev_sel         = (state_q == REQ) ? sel_q : '0;
  assign dev_we          = wr_q;
  assign dev_addr        = addr_q;
  assign dev_wdata       = wdata_q;
  assign mmio_read_done  = (state_q == RESP) && rd_q;
  assign mmio_write_done = (state_q == RESP) && wr_q;
  assign mmio_err        = (state_q == RESP) && err_q;
  assign mmio_read_data  = rdata_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: 4 devices, TIMEOUT=8, window 1 widened to overlap window 0.
module tb_mmio_bus;

  logic         clk;
  logic         rst;
  logic         mmio_read, mmio_write;
  logic [31:0]  mmio_addr, mmio_write_data;
  logic         mmio_read_done, mmio_write_done, mmio_err;
  logic [31:0]  mmio_read_data;
  logic [3:0]   dev_sel;
  logic         dev_we;
  logic [31:0]  dev_addr, dev_wdata;
  logic [127:0] dev_rdata;
  logic [3:0]   dev_ack;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_bus #(
    .N_DEV    (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT  (8),
    .DEV_BASE ({32'hFFFF_0030, 32'hFFFF_0020, 32'hFFFF_0000, 32'hFFFF_0000}),
    .DEV_MASK ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFF0}),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .sys_clk         (clk),
    .rst             (rst),
    .mmio_read       (mmio_read),
    .mmio_write      (mmio_write),
    .mmio_addr       (mmio_addr),
    .mmio_write_data (mmio_write_data),
    .mmio_read_done  (mmio_read_done),
    .mmio_write_done (mmio_write_done),
    .mmio_read_data  (mmio_read_data),
    .mmio_err        (mmio_err),
    .dev_sel         (dev_sel),
    .dev_we          (dev_we),
    .dev_addr        (dev_addr),
    .dev_wdata       (dev_wdata),
    .dev_rdata       (dev_rdata),
    .dev_ack         (dev_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_txn();
    mmio_read  = 1'b0;
    mmio_write = 1'b0;
    dev_ack    = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mmio_read = 1'b0; mmio_write = 1'b0;
    mmio_addr = '0; mmio_write_data = '0;
    dev_rdata = '0; dev_ack = '0;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({dev_sel, dev_we, mmio_read_done, mmio_write_done, mmio_err} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {dev_sel, dev_we, mmio_read_done, mmio_write_done, mmio_err});
    end
    n_tests++;
    if ({dev_addr, dev_wdata, mmio_read_data} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h exp 0", {dev_addr, dev_wdata, mmio_read_data});
    end
    $display("[TB] reset done");
  endtask

  task automatic test_read_slot2();
    dev_rdata = {32'h0, 32'h1234_5678, 64'h0};
    mmio_addr = 32'hFFFF_0024; mmio_read = 1'b1;
    tick();
    n_tests++;
    if (dev_sel !== 4'b0100 || dev_addr !== 32'h4 || dev_we !== 1'b0 || mmio_read_done !== 1'b0) begin
      n_fail++; $display("FAIL rd2_req sel=%b addr=%h we=%b done=%b exp 0100/4/0/0", dev_sel, dev_addr, dev_we, mmio_read_done);
    end
    dev_ack = 4'b0100;
    tick();
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_write_done !== 1'b0 || mmio_err !== 1'b0 || dev_sel !== 4'b0000) begin
      n_fail++; $display("FAIL rd2_done rd=%b wr=%b err=%b sel=%b exp 1/0/0/0000", mmio_read_done, mmio_write_done, mmio_err, dev_sel);
    end
    n_tests++;
    if (mmio_read_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd2_data got %h exp 12345678", mmio_read_data);
    end
    finish_txn();
    $display("[TB] read 0xFFFF0024 -> %h", mmio_read_data);
  endtask

  task automatic test_write_wait();
    mmio_addr = 32'hFFFF_0004; mmio_write_data = 32'hA5A5_A5A5; mmio_write = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (dev_sel !== 4'b0001 || dev_we !== 1'b1 || dev_wdata !== 32'hA5A5_A5A5 || mmio_write_done !== 1'b0) begin
        n_fail++; $display("FAIL wr_req%0d sel=%b we=%b wdata=%h done=%b exp 0001/1/a5a5a5a5/0", k, dev_sel, dev_we, dev_wdata, mmio_write_done);
      end
      if (k == 3) dev_ack = 4'b0001;
      tick();
    end
    n_tests++;
    if (mmio_write_done !== 1'b1 || mmio_read_done !== 1'b0 || mmio_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_done wr=%b rd=%b err=%b exp 1/0/0", mmio_write_done, mmio_read_done, mmio_err);
    end
    dev_ack = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (mmio_write_done !== 1'b0 || dev_sel !== 4'b0000) begin
        n_fail++; $display("FAIL wr_held%0d done=%b sel=%b exp 0/0000", k, mmio_write_done, dev_sel);
      end
    end
    finish_txn();
    n_tests++;
    if (dev_sel !== 4'b0000 || mmio_write_done !== 1'b0) begin
      n_fail++; $display("FAIL wr_idle sel=%b done=%b exp 0000/0", dev_sel, mmio_write_done);
    end
    $display("[TB] write 0xFFFF0004 <- a5a5a5a5 (3 waits)");
  endtask

  task automatic test_unmapped();
    mmio_addr = 32'h1000_0000; mmio_read = 1'b1;
    tick();
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_err !== 1'b1 || dev_sel !== 4'b0000 || mmio_read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL unmapped done=%b err=%b sel=%b data=%h exp 1/1/0000/deadbeef", mmio_read_done, mmio_err, dev_sel, mmio_read_data);
    end
    finish_txn();
    $display("[TB] read 0x10000000 unmapped");
  endtask

  task automatic test_timeout();
    mmio_addr = 32'hFFFF_0030; mmio_read = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (dev_sel !== 4'b1000 || mmio_read_done !== 1'b0) begin
        n_fail++; $display("FAIL to_req%0d sel=%b done=%b exp 1000/0", k, dev_sel, mmio_read_done);
      end
      tick();
    end
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_err !== 1'b1 || dev_sel !== 4'b0000 || mmio_read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL to_done done=%b err=%b sel=%b data=%h exp 1/1/0000/deadbeef", mmio_read_done, mmio_err, dev_sel, mmio_read_data);
    end
    finish_txn();
    $display("[TB] read 0xFFFF0030 timeout");
  endtask

  task automatic test_ack_at_limit();
    dev_rdata = {32'hCAFE_0003, 96'h0};
    mmio_addr = 32'hFFFF_0034; mmio_read = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 7) dev_ack = 4'b1000;
      tick();
    end
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_err !== 1'b0 || mmio_read_data !== 32'hCAFE_0003) begin
      n_fail++; $display("FAIL ack_limit done=%b err=%b data=%h exp 1/0/cafe0003", mmio_read_done, mmio_err, mmio_read_data);
    end
    finish_txn();
    $display("[TB] read 0xFFFF0034 ack on last cycle");
  endtask

  task automatic test_reset_mid_req();
    dev_rdata = {32'h0, 32'h0000_0055, 64'h0};
    mmio_addr = 32'hFFFF_0028; mmio_read = 1'b1;
    tick(); tick();
    rst = 1'b1; dev_ack = 4'b0100;
    tick();
    n_tests++;
    if (dev_sel !== 4'b0000 || mmio_read_done !== 1'b0 || mmio_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid sel=%b done=%b err=%b exp 0000/0/0", dev_sel, mmio_read_done, mmio_err);
    end
    rst = 1'b0; dev_ack = 4'b0000;
    tick();
    n_tests++;
    if (dev_sel !== 4'b0100 || dev_addr !== 32'h8 || mmio_read_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_reissue sel=%b addr=%h done=%b exp 0100/8/0", dev_sel, dev_addr, mmio_read_done);
    end
    dev_ack = 4'b0100;
    tick();
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_err !== 1'b0 || mmio_read_data !== 32'h0000_0055) begin
      n_fail++; $display("FAIL rst_complete done=%b err=%b data=%h exp 1/0/55", mmio_read_done, mmio_err, mmio_read_data);
    end
    finish_txn();
    $display("[TB] read 0xFFFF0028 across reset");
  endtask

  task automatic test_illegal();
    mmio_addr = 32'hFFFF_0024; mmio_read = 1'b1; mmio_write = 1'b1;
    tick();
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_write_done !== 1'b1 || mmio_err !== 1'b1 || dev_sel !== 4'b0000 || mmio_read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL illegal rd=%b wr=%b err=%b sel=%b data=%h exp 1/1/1/0000/deadbeef", mmio_read_done, mmio_write_done, mmio_err, dev_sel, mmio_read_data);
    end
    finish_txn();
    $display("[TB] read+write 0xFFFF0024 illegal");
  endtask

  task automatic test_overlap();
    logic [31:0] addrs [2]   = '{32'hFFFF_0008, 32'hFFFF_0014};
    logic [3:0]  sels  [2]   = '{4'b0001, 4'b0010};
    logic [31:0] offs  [2]   = '{32'h8, 32'h14};
    logic [31:0] datas [2]   = '{32'h1111_0000, 32'h2222_0001};
    dev_rdata = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    for (int v = 0; v < 2; v++) begin
      mmio_addr = addrs[v]; mmio_read = 1'b1;
      tick();
      n_tests++;
      if (dev_sel !== sels[v] || dev_addr !== offs[v]) begin
        n_fail++; $display("FAIL overlap%0d_sel sel=%b addr=%h exp %b/%h", v, dev_sel, dev_addr, sels[v], offs[v]);
      end
      dev_ack = sels[v];
      tick();
      n_tests++;
      if (mmio_read_done !== 1'b1 || mmio_err !== 1'b0 || mmio_read_data !== datas[v]) begin
        n_fail++; $display("FAIL overlap%0d_data done=%b err=%b data=%h exp 1/0/%h", v, mmio_read_done, mmio_err, mmio_read_data, datas[v]);
      end
      finish_txn();
      $display("[TB] read %h overlap -> %h", addrs[v], mmio_read_data);
    end
  endtask

  task automatic test_back_to_back();
    dev_rdata = {32'h0, 32'hBBBB_0002, 64'h0};
    mmio_addr = 32'hFFFF_0020; mmio_read = 1'b1;
    tick();
    dev_ack = 4'b0010;
    tick();
    n_tests++;
    if (dev_sel !== 4'b0100 || mmio_read_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_foreign_ack sel=%b done=%b exp 0100/0", dev_sel, mmio_read_done);
    end
    dev_ack = 4'b0100;
    tick();
    n_tests++;
    if (mmio_read_done !== 1'b1 || mmio_read_data !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL b2b_first done=%b data=%h exp 1/bbbb0002", mmio_read_done, mmio_read_data);
    end
    mmio_read = 1'b0; dev_ack = 4'b0000;
    tick();
    tick();
    mmio_addr = 32'hFFFF_0010; mmio_write = 1'b1; mmio_write_data = 32'h0000_BEEF;
    tick();
    n_tests++;
    if (dev_sel !== 4'b0010 || dev_we !== 1'b1 || dev_addr !== 32'h10 || dev_wdata !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL b2b_second sel=%b we=%b addr=%h wdata=%h exp 0010/1/10/0000beef", dev_sel, dev_we, dev_addr, dev_wdata);
    end
    dev_ack = 4'b0010;
    tick();
    n_tests++;
    if (mmio_write_done !== 1'b1 || mmio_err !== 1'b0 || mmio_read_data !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL b2b_second_done wr=%b err=%b data=%h exp 1/0/bbbb0002", mmio_write_done, mmio_err, mmio_read_data);
    end
    finish_txn();
    $display("[TB] back-to-back read 0xFFFF0020, write 0xFFFF0010");
  endtask

  initial begin
    test_reset();
    test_read_slot2();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_req();
    test_illegal();
    test_overlap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
